decode_unit: RTL and testbench

Second pipeline stage of the RISCAT RV32I core. Consumes the `IF_ID` register produced by the fetch stage and drives the registered `ID_EX` pipeline register consumed by execute. It contains the 32×32 integer register file, with a write port driven by writeback, and generates immediates and control signals. It also detects load-use hazards, stalling fetch and injecting a bubble.

---
 rtl/decode_unit.sv | 217 +++++++++++++++++++++
 tb/tb_decode_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// RISCAT RV32I decode stage: register file with writeback bypass, immediate and
// control generation, load-use hazard detection, and the registered ID_EX stage.
package decode_unit_pkg;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] fetched_inst;
    logic        do_not_execute;
  } IF_ID;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        do_not_execute;
  } ID_EX;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

endpackage

module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  IF_ID            if_id_r,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output ID_EX            id_ex_r
);

  logic [XLEN-1:0] rf_q [32];
  ID_EX            id_ex_q, id_ex_d;
  ID_EX            dec;
  logic [31:0]     inst;
  logic [PC_W-1:0] pc_w;
  logic            use_rs1, use_rs2, known, valid, hazard;
  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign inst = if_id_r.fetched_inst;
  assign pc_w = if_id_r.pc;

  // inst[30] selects SUB only for register-register ops; for immediates it is imm bits
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic b30,
                                      input logic imm_form);
    case (f3)
      3'd0:    alu_sel = (b30 && !imm_form) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_sel = ALU_SLL;
      3'd2:    alu_sel = ALU_SLT;
      3'd3:    alu_sel = ALU_SLTU;
      3'd4:    alu_sel = ALU_XOR;
      3'd5:    alu_sel = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec        = '0;
    known      = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec.pc     = pc_w;
    dec.funct3 = inst[14:12];
    dec.rd     = inst[11:7];
    case (inst[6:0])
      OPC_LUI: begin
        known = 1'b1;
        dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.imm = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        known = 1'b1;
        dec.alu_op = ALU_ADD; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        known = 1'b1;
        dec.alu_op = ALU_ADD; dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        known = 1'b1; use_rs1 = 1'b1;
        dec.alu_op = ALU_ADD; dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.rd = '0;
        dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LOAD: begin
        known = 1'b1; use_rs1 = 1'b1;
        dec.alu_op = ALU_ADD; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_op = ALU_ADD; dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
        dec.rd = '0;
        dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OPIMM: begin
        known = 1'b1; use_rs1 = 1'b1;
        dec.alu_op = alu_sel(inst[14:12], inst[30], 1'b1);
        dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
        dec.imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP: begin
        known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_op = alu_sel(inst[14:12], inst[30], 1'b0);
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign valid   = known && !if_id_r.do_not_execute && (inst != '0);
  assign rs1_idx = (valid && use_rs1) ? inst[19:15] : 5'd0;
  assign rs2_idx = (valid && use_rs2) ? inst[24:20] : 5'd0;

  // Same-cycle writeback is forwarded so the array write needs no extra cycle
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != 5'd0)
      rs1_val = (wb_we && wb_rd == rs1_idx) ? wb_data : rf_q[rs1_idx];
    if (rs2_idx != 5'd0)
      rs2_val = (wb_we && wb_rd == rs2_idx) ? wb_data : rf_q[rs2_idx];
  end

  assign hazard = id_ex_q.mem_read && !id_ex_q.do_not_execute && (id_ex_q.rd != 5'd0) &&
                  (((rs1_idx != 5'd0) && (rs1_idx == id_ex_q.rd)) ||
                   ((rs2_idx != 5'd0) && (rs2_idx == id_ex_q.rd)));
  assign stall  = hazard && !flush;

  always_comb begin
    id_ex_d         = dec;
    id_ex_d.rs1     = rs1_idx;
    id_ex_d.rs2     = rs2_idx;
    id_ex_d.rs1_val = rs1_val;
    id_ex_d.rs2_val = rs2_val;
    if (flush || hazard || !valid) begin
      id_ex_d                = '0;
      id_ex_d.pc             = pc_w;
      id_ex_d.do_not_execute = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q                <= '0;
      id_ex_q.do_not_execute <= 1'b1;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign id_ex_r = id_ex_q;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: expected ID_EX records are queued as each
// instruction is driven and compared once the stage register has captured it.
module tb_decode_unit;
  import decode_unit_pkg::*;

  logic        clk;
  logic        reset;
  IF_ID        if_id_r;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  ID_EX        id_ex_r;

  int checks = 0;
  int errors = 0;
  ID_EX exp_q[$];

  localparam logic [6:0] F_IMM = 7'b1000000;
  localparam logic [6:0] F_PC  = 7'b0100000;
  localparam logic [6:0] F_MR  = 7'b0010000;
  localparam logic [6:0] F_MW  = 7'b0001000;
  localparam logic [6:0] F_RW  = 7'b0000100;
  localparam logic [6:0] F_BR  = 7'b0000010;
  localparam logic [6:0] F_JMP = 7'b0000001;

  decode_unit #(.XLEN(32), .PC_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .if_id_r (if_id_r),
    .flush   (flush),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .stall   (stall),
    .id_ex_r (id_ex_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic IF_ID fi(input logic [15:0] pc, input logic [31:0] inst);
    IF_ID f;
    f.pc = pc; f.fetched_inst = inst; f.do_not_execute = 1'b0;
    return f;
  endfunction

  function automatic ID_EX bub(input logic [15:0] pc);
    ID_EX e;
    e = '0; e.pc = pc; e.do_not_execute = 1'b1;
    return e;
  endfunction

  function automatic ID_EX mk(input logic [15:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [3:0] alu,
                              input logic [6:0] fl);
    ID_EX e;
    e.pc = pc; e.rs1_val = v1; e.rs2_val = v2; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.funct3 = f3; e.alu_op = alu;
    {e.alu_src_imm, e.alu_src_pc, e.mem_read, e.mem_write, e.reg_write, e.branch, e.jump} = fl;
    e.do_not_execute = 1'b0;
    return e;
  endfunction

  // One decode cycle: drive at negedge, check stall, queue expectation, compare after edge
  task automatic cyc(input string tag, input IF_ID f, input logic fl, input logic we,
                     input logic [4:0] rd, input logic [31:0] d, input logic es, input ID_EX e);
    ID_EX got_exp;
    @(negedge clk);
    if_id_r = f; flush = fl; wb_we = we; wb_rd = rd; wb_data = d;
    #1;
    check({tag, "_stall"}, stall, es);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      got_exp = exp_q.pop_front();
      check(tag, id_ex_r, got_exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    if_id_r = fi(16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_idex", id_ex_r, bub(16'h0));
    check("reset_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    cyc("addi_bypass", fi(16'h10, 32'hFFF28313), 0, 1, 5, 32'h12345678, 0,
        mk(16'h10, 32'h12345678, 0, 32'hFFFFFFFF, 6, 5, 0, 0, ALU_ADD, F_IMM | F_RW));
    cyc("add_array", fi(16'h14, 32'h000284B3), 0, 1, 1, 32'h100, 0,
        mk(16'h14, 32'h12345678, 0, 0, 9, 5, 0, 0, ALU_ADD, F_RW));
    cyc("srai", fi(16'h18, 32'h40325193), 0, 1, 2, 32'h55, 0,
        mk(16'h18, 0, 0, 32'h403, 3, 4, 0, 5, ALU_SRA, F_IMM | F_RW));
    cyc("lw", fi(16'h20, 32'h0000A383), 0, 0, 0, 0, 0,
        mk(16'h20, 32'h100, 0, 0, 7, 1, 0, 2, ALU_ADD, F_IMM | F_MR | F_RW));
    cyc("loaduse_bubble", fi(16'h24, 32'h00238433), 0, 1, 7, 32'hCAFE, 1, bub(16'h24));
    cyc("loaduse_issue", fi(16'h24, 32'h00238433), 0, 0, 0, 0, 0,
        mk(16'h24, 32'hCAFE, 32'h55, 0, 8, 7, 2, 0, ALU_ADD, F_RW));
    cyc("sub", fi(16'h28, 32'h40228633), 0, 0, 0, 0, 0,
        mk(16'h28, 32'h12345678, 32'h55, 0, 12, 5, 2, 0, ALU_SUB, F_RW));
    cyc("sw", fi(16'h2C, 32'h0020A223), 0, 0, 0, 0, 0,
        mk(16'h2C, 32'h100, 32'h55, 4, 0, 1, 2, 2, ALU_ADD, F_IMM | F_MW));
    cyc("lui", fi(16'h30, 32'hABCDE6B7), 0, 0, 0, 0, 0,
        mk(16'h30, 0, 0, 32'hABCDE000, 13, 0, 0, 6, ALU_PASS_B, F_IMM | F_RW));
    cyc("auipc", fi(16'h34, 32'h00001717), 0, 0, 0, 0, 0,
        mk(16'h34, 0, 0, 32'h1000, 14, 0, 0, 1, ALU_ADD, F_IMM | F_PC | F_RW));
    cyc("jal", fi(16'h40, 32'h008000EF), 0, 0, 0, 0, 0,
        mk(16'h40, 0, 0, 32'h8, 1, 0, 0, 0, ALU_ADD, F_RW | F_JMP));
    cyc("beq", fi(16'h44, 32'hFE000EE3), 0, 0, 0, 0, 0,
        mk(16'h44, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, ALU_SUB, F_BR));
    cyc("x0_write_bypass", fi(16'h48, 32'h00500513), 0, 1, 0, 32'hDEAD, 0,
        mk(16'h48, 0, 0, 5, 10, 0, 0, 0, ALU_ADD, F_IMM | F_RW));
    cyc("x0_read", fi(16'h4C, 32'h00500513), 0, 0, 0, 0, 0,
        mk(16'h4C, 0, 0, 5, 10, 0, 0, 0, ALU_ADD, F_IMM | F_RW));
    cyc("unlisted_op", fi(16'h50, 32'h0000000F), 0, 0, 0, 0, 0, bub(16'h50));
    cyc("zero_inst", fi(16'h54, 32'h0), 0, 0, 0, 0, 0, bub(16'h54));
    begin
      IF_ID f;
      f = fi(16'h58, 32'h00500513);
      f.do_not_execute = 1'b1;
      cyc("dne_in", f, 0, 0, 0, 0, 0, bub(16'h58));
    end
    cyc("lw2", fi(16'h60, 32'h0000A383), 0, 0, 0, 0, 0,
        mk(16'h60, 32'h100, 0, 0, 7, 1, 0, 2, ALU_ADD, F_IMM | F_MR | F_RW));
    cyc("flush_hazard", fi(16'h64, 32'h00238433), 1, 0, 0, 0, 0, bub(16'h64));
    cyc("after_flush", fi(16'h64, 32'h00238433), 0, 0, 0, 0, 0,
        mk(16'h64, 32'hCAFE, 32'h55, 0, 8, 7, 2, 0, ALU_ADD, F_RW));
    cyc("lw3", fi(16'h70, 32'h0000A383), 0, 0, 0, 0, 0,
        mk(16'h70, 32'h100, 0, 0, 7, 1, 0, 2, ALU_ADD, F_IMM | F_MR | F_RW));
    cyc("no_dep", fi(16'h74, 32'h40228633), 0, 0, 0, 0, 0,
        mk(16'h74, 32'h12345678, 32'h55, 0, 12, 5, 2, 0, ALU_SUB, F_RW));
    cyc("lw_pre_rst", fi(16'h80, 32'h0000A383), 0, 0, 0, 0, 0,
        mk(16'h80, 32'h100, 0, 0, 7, 1, 0, 2, ALU_ADD, F_IMM | F_MR | F_RW));

    // Reset lands mid-hazard with a write pending
    @(negedge clk);
    if_id_r = fi(16'h84, 32'h00238433); flush = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h777;
    #1;
    check("pre_rst_stall", stall, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_stall", stall, 0);
    check("rst_idex", id_ex_r, bub(16'h0));
    @(posedge clk);
    #1;
    check("rst_hold_idex", id_ex_r, bub(16'h0));
    @(negedge clk);
    wb_we = 1'b0;
    reset = 1'b0;

    cyc("post_rst_sub", fi(16'h90, 32'h40228633), 0, 0, 0, 0, 0,
        mk(16'h90, 0, 0, 0, 12, 5, 2, 0, ALU_SUB, F_RW));
    cyc("post_rst_add", fi(16'h94, 32'h00238433), 0, 0, 0, 0, 0,
        mk(16'h94, 0, 0, 0, 8, 7, 2, 0, ALU_ADD, F_RW));
    cyc("post_rst_sw", fi(16'h98, 32'h0020A223), 0, 0, 0, 0, 0,
        mk(16'h98, 0, 0, 4, 0, 1, 2, 2, ALU_ADD, F_IMM | F_MW));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
